iter_divider: RTL and testbench

Parametrised multi-cycle radix-2 restoring integer divider for the execute stage's long-latency unit, replacing the fixed 64-bit divider. It supports any even XLEN, signed/unsigned operation, RV64 32-bit "W" mode, and single-cycle RISC-V divide-by-zero/overflow results. It also provides full valid/ready handshakes on both sides (output backpressure) and a pipeline flush.

---
 rtl/iter_divider.sv | 174 +++++++++++++++++
 tb/tb_iter_divider.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// iter_divider: multi-cycle radix-2 restoring integer divider.
// Produces one quotient bit per cycle. It supports signed and unsigned
// operation and an optional RV64 32-bit word mode. Divide-by-zero and signed
// overflow are resolved at accept time. Both sides use valid/ready handshakes,
// and flush aborts any operation in flight.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for operands; in_ready=1
// CALC  | one restoring-division iteration per cycle, W cycles total
// FIX   | apply result signs, sign-extend in word mode, load outputs
// DONE  | result presented (out_valid=1), held until out_ready

module iter_divider #(
    parameter int XLEN    = 64,
    parameter bit WORD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            div_signed,
    input  logic            div_word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    // Word-mode width. It is clamped to XLEN so that narrow builds, which
    // never enable word mode, still elaborate with legal bit indices.
    localparam int WB = (XLEN >= 32) ? 32 : XLEN;
    localparam int SH = XLEN - WB;
    localparam int CW = $clog2(XLEN);

    // All ones from bit WB-1 upward. This is the most-negative word value
    // after sign extension.
    localparam logic [XLEN-1:0] MIN_WORD = ~((XLEN'(1) << (WB - 1)) - XLEN'(1));
    localparam logic [XLEN-1:0] MIN_FULL = XLEN'(1) << (XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nx;

    // Iteration registers.
    logic [XLEN-1:0] dvs_r;      // divisor magnitude
    logic [XLEN-1:0] q_r;        // dividend bits shifting out, quotient bits shifting in
    logic [XLEN-1:0] rem_r;      // partial remainder, always < dvs_r
    logic [CW-1:0]   cnt_r;
    logic            word_r;
    logic            neg_q_r;
    logic            neg_r_r;

    function automatic logic [XLEN-1:0] sext_wb(input logic [XLEN-1:0] x);
        logic signed [XLEN-1:0] t;
        t = x << SH;
        return t >>> SH;
    endfunction

    function automatic logic [XLEN-1:0] zext_wb(input logic [XLEN-1:0] x);
        return (x << SH) >> SH;
    endfunction

    // Accept-side operand conditioning.
    logic            word_mode;
    logic [XLEN-1:0] a_sx, b_sx, a_zx, b_zx;
    logic            a_s, b_s;
    logic [XLEN-1:0] a_mag, b_mag, q_init;
    logic            div_zero, overflow, accept;

    assign word_mode = WORD_EN && div_word;
    assign a_sx      = word_mode ? sext_wb(dividend) : dividend;
    assign b_sx      = word_mode ? sext_wb(divisor)  : divisor;
    assign a_zx      = word_mode ? zext_wb(dividend) : dividend;
    assign b_zx      = word_mode ? zext_wb(divisor)  : divisor;
    assign a_s       = div_signed & (word_mode ? dividend[WB-1] : dividend[XLEN-1]);
    assign b_s       = div_signed & (word_mode ? divisor[WB-1]  : divisor[XLEN-1]);
    assign a_mag     = a_s ? -a_sx : a_zx;
    assign b_mag     = b_s ? -b_sx : b_zx;
    // In word mode the dividend is pre-aligned to the top so the MSB shifted
    // out on the first iteration is dividend bit 31.
    assign q_init    = word_mode ? (a_mag << SH) : a_mag;
    assign div_zero  = (b_zx == '0);
    assign overflow  = div_signed && (a_sx == (word_mode ? MIN_WORD : MIN_FULL)) && (b_sx == '1);
    assign accept    = in_valid && (state == IDLE) && !flush;
    assign in_ready  = (state == IDLE);

    // One restoring step: shift, trial-subtract, keep on no borrow.
    logic [XLEN:0]   sh;
    logic            borrow;
    logic [XLEN-1:0] rem_nx, q_nx;
    logic            last_iter;

    assign sh        = {rem_r, q_r[XLEN-1]};
    assign borrow    = (sh < {1'b0, dvs_r});
    assign rem_nx    = borrow ? sh[XLEN-1:0] : XLEN'(sh - {1'b0, dvs_r});
    assign q_nx      = {q_r[XLEN-2:0], ~borrow};
    assign last_iter = (cnt_r == (word_r ? CW'(WB - 1) : CW'(XLEN - 1)));

    // Final sign correction and word-mode extension.
    logic [XLEN-1:0] q_mag, q_sgn, q_fin, r_sgn, r_fin;

    assign q_mag = word_r ? zext_wb(q_r) : q_r;
    assign q_sgn = neg_q_r ? -q_mag : q_mag;
    assign q_fin = word_r ? sext_wb(q_sgn) : q_sgn;
    assign r_sgn = neg_r_r ? -rem_r : rem_r;
    assign r_fin = word_r ? sext_wb(r_sgn) : r_sgn;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = (div_zero || overflow) ? DONE : CALC;
            CALC: if (last_iter) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // Datapath: operand capture, iteration, and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            cnt_r     <= '0;
        end else begin
            out_valid <= (state_nx == DONE);
            if (accept) begin
                dvs_r   <= b_mag;
                q_r     <= q_init;
                rem_r   <= '0;
                cnt_r   <= '0;
                word_r  <= word_mode;
                neg_q_r <= a_s ^ b_s;
                neg_r_r <= a_s;
                if (div_zero) begin
                    quotient  <= '1;
                    remainder <= a_sx;
                end else if (overflow) begin
                    quotient  <= a_sx;
                    remainder <= '0;
                end
            end else if (state == CALC) begin
                q_r   <= q_nx;
                rem_r <= rem_nx;
                cnt_r <= cnt_r + CW'(1);
            end else if (state == FIX && !flush) begin
                quotient  <= q_fin;
                remainder <= r_fin;
            end
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Testbench for iter_divider: directed and randomized divisions checked
// against an arithmetic reference model. It covers XLEN=64 with word mode
// and an XLEN=16 instance.

module tb_iter_divider;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [63:0] dividend, divisor, quotient, remainder;
    logic        div_signed, div_word;

    logic        in_valid_16, in_ready_16, out_valid_16, out_ready_16;
    logic [15:0] dividend_16, divisor_16, quotient_16, remainder_16;
    logic        div_signed_16, div_word_16;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    iter_divider #(.XLEN(64), .WORD_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .div_signed(div_signed), .div_word(div_word),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder)
    );

    iter_divider #(.XLEN(16), .WORD_EN(1'b0)) dut16 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid_16), .in_ready(in_ready_16),
        .dividend(dividend_16), .divisor(divisor_16),
        .div_signed(div_signed_16), .div_word(div_word_16),
        .out_valid(out_valid_16), .out_ready(out_ready_16),
        .quotient(quotient_16), .remainder(remainder_16)
    );

    function automatic logic [63:0] sx32(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    // Reference: RISC-V division semantics using native arithmetic.
    task automatic ref64(input logic [63:0] a, b, input logic sg, wd,
                         output logic [63:0] q, r, output int lat);
        longint sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        int ia, ib;
        int unsigned wa, wb;
        ia = a[31:0]; ib = b[31:0]; wa = a[31:0]; wb = b[31:0];
        if (wd) begin sa = ia; sb = ib; ua = wa; ub = wb; end
        else    begin sa = a;  sb = b;  ua = a;  ub = b;  end
        lat = wd ? 34 : 66;
        if (ub == 0) begin
            q = '1; r = wd ? sx32(a) : a; lat = 1;
        end else if (sg && sb == -1 && (wd ? (wa == 32'h8000_0000) : (a == 64'h8000_0000_0000_0000))) begin
            q = wd ? sx32(a) : a; r = '0; lat = 1;
        end else begin
            if (sg) begin sq = sa / sb; sr = sa % sb; q = sq; r = sr; end
            else    begin uq = ua / ub; ur = ua % ub; q = uq; r = ur; end
            if (wd) begin q = sx32(q); r = sx32(r); end
        end
    endtask

    // Called at a negedge in a cycle where in_ready should be 1; the
    // operation is accepted at the next posedge (cycle 0). Returns at the
    // negedge of the cycle after consumption, with in_ready expected high.
    task automatic run_op(input string nm, input logic [63:0] a, b,
                          input logic sg, wd, input int hold);
        logic [63:0] eq, er;
        int elat, lat;
        ref64(a, b, sg, wd, eq, er, elat);
        dividend = a; divisor = b; div_signed = sg; div_word = wd;
        in_valid = 1'b1; out_ready = 1'b0;
        n_run++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s accept: in_ready=%b want 1", nm, in_ready);
        end
        @(negedge clk);
        in_valid = $urandom; dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom};
        div_signed = $urandom; div_word = $urandom;
        n_run++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s busy: in_ready=%b want 0", nm, in_ready);
        end
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk); lat++;
        end
        n_run++;
        if (out_valid !== 1'b1 || lat != elat) begin
            n_fail++; $display("FAIL %s latency: got %0d (out_valid=%b) want %0d", nm, lat, out_valid, elat);
        end
        n_run++;
        if (quotient !== eq) begin
            n_fail++; $display("FAIL %s quotient: got %h want %h", nm, quotient, eq);
        end
        n_run++;
        if (remainder !== er) begin
            n_fail++; $display("FAIL %s remainder: got %h want %h", nm, remainder, er);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_run++;
            if (out_valid !== 1'b1 || quotient !== eq || remainder !== er || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hold%0d: out_valid=%b q=%h r=%h in_ready=%b want 1 %h %h 0",
                         nm, h, out_valid, quotient, remainder, in_ready, eq, er);
            end
        end
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        n_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s consume: out_valid=%b in_ready=%b want 0 1", nm, out_valid, in_ready);
        end
    endtask

    task automatic run_op16(input string nm, input logic [15:0] a, b, input logic sg);
        logic [15:0] eq, er;
        shortint sa, sb;
        int elat, lat;
        sa = a; sb = b;
        elat = 18;
        if (b == 16'h0) begin eq = '1; er = a; elat = 1; end
        else if (sg && a == 16'h8000 && b == 16'hFFFF) begin eq = a; er = '0; elat = 1; end
        else if (sg) begin eq = sa / sb; er = sa % sb; end
        else begin eq = a / b; er = a % b; end
        dividend_16 = a; divisor_16 = b; div_signed_16 = sg; div_word_16 = $urandom;
        in_valid_16 = 1'b1; out_ready_16 = 1'b1;
        @(negedge clk);
        in_valid_16 = 1'b0; dividend_16 = 16'($urandom); divisor_16 = 16'($urandom);
        lat = 1;
        while (out_valid_16 !== 1'b1 && lat < 50) begin
            @(negedge clk); lat++;
        end
        n_run++;
        if (out_valid_16 !== 1'b1 || lat != elat || quotient_16 !== eq || remainder_16 !== er) begin
            n_fail++;
            $display("FAIL %s: lat=%0d q=%h r=%h want lat=%0d q=%h r=%h", nm, lat, quotient_16, remainder_16, elat, eq, er);
        end
        @(negedge clk);
        n_run++;
        if (out_valid_16 !== 1'b0 || in_ready_16 !== 1'b1) begin
            n_fail++; $display("FAIL %s consume: out_valid=%b in_ready=%b want 0 1", nm, out_valid_16, in_ready_16);
        end
    endtask

    task automatic test_reset;
        n_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 64'h0 || remainder !== 64'h0) begin
            n_fail++;
            $display("FAIL reset64: in_ready=%b out_valid=%b q=%h r=%h want 1 0 0 0", in_ready, out_valid, quotient, remainder);
        end
        n_run++;
        if (in_ready_16 !== 1'b1 || out_valid_16 !== 1'b0 || quotient_16 !== 16'h0 || remainder_16 !== 16'h0) begin
            n_fail++;
            $display("FAIL reset16: in_ready=%b out_valid=%b q=%h r=%h want 1 0 0 0",
                     in_ready_16, out_valid_16, quotient_16, remainder_16);
        end
    endtask

    task automatic test_directed;
        run_op("u100_7",   64'd100, 64'd7, 1'b0, 1'b0, 0);
        run_op("s-7_2",    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 0);
        run_op("s7_-2",    64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 0);
        run_op("s5_0",     64'd5, 64'd0, 1'b1, 1'b0, 0);
        run_op("ovf64",    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0);
        run_op("w_s-7_2",  64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 0);
        run_op("w_u_by1",  64'h1234_5678_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 0);
        run_op("w_ovf",    64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 0);
        run_op("u_big",    64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0, 1'b0, 0);
    endtask

    task automatic test_backpressure;
        run_op("bp100_7", 64'd100, 64'd7, 1'b0, 1'b0, 5);
        run_op("bp_zero", 64'h1234, 64'd0, 1'b0, 1'b1, 3);
    endtask

    task automatic test_random;
        logic [63:0] a, b;
        logic sg, wd;
        for (int i = 0; i < 40; i++) begin
            sg = $urandom; wd = $urandom;
            case ($urandom_range(0, 5))
                0: begin a = {$urandom, $urandom}; b = wd ? {$urandom, 32'h0} : 64'h0; end
                1: begin
                    sg = 1'b1;
                    a = wd ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = wd ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
                end
                2: begin
                    a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 20));
                    if ($urandom_range(0, 1) == 1) a = -a;
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                default: begin
                    a = {$urandom, $urandom};
                    b = {$urandom, $urandom} >> $urandom_range(0, 60);
                end
            endcase
            run_op("rand", a, b, sg, wd, $urandom_range(0, 3));
        end
    endtask

    task automatic test_flush;
        dividend = 64'd100; divisor = 64'd7; div_signed = 1'b0; div_word = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k < 10; k++) begin
            n_run++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL flush_busy c%0d: out_valid=%b in_ready=%b want 0 0", k, out_valid, in_ready);
            end
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_calc: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        run_op("flush_new9_3", 64'd9, 64'd3, 1'b0, 1'b0, 0);
        // Flush a held special-case result.
        dividend = 64'd5; divisor = 64'd0; div_signed = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_done: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid;
        dividend = 64'd100; divisor = 64'd7; div_signed = 1'b0; div_word = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 64'h0 || remainder !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b q=%h r=%h want 1 0 0 0", in_ready, out_valid, quotient, remainder);
        end
        run_op("after_reset", 64'd1000, 64'd33, 1'b0, 1'b0, 0);
    endtask

    task automatic test_xlen16;
        run_op16("x16_ffff_3", 16'hFFFF, 16'h0003, 1'b0);
        run_op16("x16_s_neg",  16'hFFF9, 16'h0002, 1'b1);
        run_op16("x16_zero",   16'h1234, 16'h0000, 1'b0);
        run_op16("x16_ovf",    16'h8000, 16'hFFFF, 1'b1);
        for (int i = 0; i < 8; i++)
            run_op16("x16_rand", 16'($urandom), 16'($urandom_range(1, 65535)), 1'($urandom));
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        div_signed = 1'b0; div_word = 1'b0;
        in_valid_16 = 1'b0; out_ready_16 = 1'b0; dividend_16 = '0; divisor_16 = '0;
        div_signed_16 = 1'b0; div_word_16 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        test_xlen16();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
